// File: rtl/result_aggregator.sv
// Collects one accumulator per MC core, sums a complete batch serially and
// publishes the saturated mean with a valid/ready handshake.
module result_aggregator #(
    parameter int CoreN    = 2,
    parameter int AccWidth = 27,
    parameter int logCoreN = 1,
    parameter int logPaths = 9
) (
    input  logic                      CLK,
    input  logic                      iRST_n,
    input  logic [CoreN*AccWidth-1:0] iAcc,
    input  logic [CoreN-1:0]          iDone,
    input  logic                      iReady,
    output logic [17:0]               oMean,
    output logic                      oValid,
    output logic                      oSat,
    output logic                      oBusy,
    output logic                      oOverrun,
    output logic [15:0]               oCount
);

    localparam int SumW = AccWidth + logCoreN;
    localparam int IdxW = (logCoreN > 0) ? logCoreN : 1;
    localparam int QW   = (SumW > 18) ? SumW : 18;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CoreN - 1);

    typedef enum logic [1:0] {COLLECT, SUM, DIV, HOLD} state_e;

    state_e state_q, state_d;

    logic [AccWidth-1:0] cap_q  [CoreN];
    logic [AccWidth-1:0] cap_d  [CoreN];
    logic [AccWidth-1:0] work_q [CoreN];
    logic [AccWidth-1:0] work_d [CoreN];
    logic [CoreN-1:0]    flag_q, flag_d;
    logic [SumW-1:0]     sum_q, sum_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [17:0]         mean_q, mean_d;
    logic                sat_q, sat_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic [15:0]         count_q, count_d;

    logic                batch_start;
    logic [QW-1:0]       quot;

    assign batch_start = (state_q == COLLECT) && (&flag_q);
    assign quot        = QW'(sum_q >> logPaths);

    always_ff @(posedge CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (batch_start) state_d = SUM;
            SUM:     if (idx_q == LastIdx) state_d = DIV;
            DIV:     state_d = HOLD;
            HOLD:    if (iReady) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        oMean    = mean_q;
        oValid   = valid_q;
        oSat     = sat_q;
        oBusy    = (state_q == SUM) || (state_q == DIV);
        oOverrun = overrun_q;
        oCount   = count_q;
    end

    // A pulse on the edge that hands the batch to the working registers refills the slot.
    always_comb begin
        cap_d     = cap_q;
        flag_d    = flag_q;
        overrun_d = overrun_q;
        for (int i = 0; i < CoreN; i++) begin
            if (iDone[i] && (!flag_q[i] || batch_start)) begin
                cap_d[i]  = iAcc[i*AccWidth +: AccWidth];
                flag_d[i] = 1'b1;
            end else if (iDone[i]) begin
                overrun_d = 1'b1;
            end else if (batch_start) begin
                flag_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        work_d  = work_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        mean_d  = mean_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            COLLECT: begin
                if (batch_start) begin
                    work_d = cap_q;
                    sum_d  = '0;
                    idx_d  = '0;
                end
            end
            SUM: begin
                sum_d = sum_q + SumW'(work_q[idx_q]);
                idx_d = idx_q + IdxW'(1);
            end
            DIV: begin
                if (quot > QW'(18'h3FFFF)) begin
                    mean_d = '1;
                    sat_d  = 1'b1;
                end else begin
                    mean_d = quot[17:0];
                    sat_d  = 1'b0;
                end
                valid_d = 1'b1;
            end
            HOLD: begin
                if (iReady) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < CoreN; i++) begin
                cap_q[i]  <= '0;
                work_q[i] <= '0;
            end
            flag_q    <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            mean_q    <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            cap_q     <= cap_d;
            work_q    <= work_d;
            flag_q    <= flag_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            mean_q    <= mean_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_result_aggregator.sv
// Bench for result_aggregator: a batch-level model predicts every output each
// cycle, and directed scenarios pin literal means, latencies and counters.
module tb_result_aggregator;

    localparam int CoreN    = 2;
    localparam int AccWidth = 27;
    localparam int LogPaths = 9;

    logic                      CLK    = 1'b0;
    logic                      iRST_n = 1'b0;
    logic [CoreN*AccWidth-1:0] iAcc   = '0;
    logic [CoreN-1:0]          iDone  = '0;
    logic                      iReady = 1'b1;
    logic [17:0]               oMean;
    logic                      oValid;
    logic                      oSat;
    logic                      oBusy;
    logic                      oOverrun;
    logic [15:0]               oCount;

    int checks_total  = 0;
    int checks_passed = 0;

    result_aggregator #(
        .CoreN(CoreN), .AccWidth(AccWidth), .logCoreN(1), .logPaths(LogPaths)
    ) dut (
        .CLK(CLK), .iRST_n(iRST_n), .iAcc(iAcc), .iDone(iDone), .iReady(iReady),
        .oMean(oMean), .oValid(oValid), .oSat(oSat), .oBusy(oBusy),
        .oOverrun(oOverrun), .oCount(oCount)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    endtask

    // Batch-level model: one pending slot per core, an engine that owns a batch
    // from hand-off until acceptance, and a queue of expected results.
    longint slot_val  [CoreN] = '{default: 0};
    bit     slot_full [CoreN] = '{default: 0};
    bit     m_engaged = 0;
    bit     m_valid   = 0;
    bit     m_overrun = 0;
    int     m_cd      = 0;
    int     m_count   = 0;
    longint exp_mean [$];
    bit     exp_sat  [$];

    always @(posedge CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < CoreN; i++) begin
                slot_val[i]  = 0;
                slot_full[i] = 0;
            end
            m_engaged = 0;
            m_valid   = 0;
            m_overrun = 0;
            m_cd      = 0;
            m_count   = 0;
            exp_mean.delete();
            exp_sat.delete();
        end else begin
            bit     take;
            bit     accept;
            longint total;
            longint q;
            take   = !m_engaged;
            for (int i = 0; i < CoreN; i++) take = take & slot_full[i];
            accept = m_valid && iReady;
            if (take) begin
                total = 0;
                for (int i = 0; i < CoreN; i++) total += slot_val[i];
                q = total >> LogPaths;
                exp_mean.push_back((q > 262143) ? 262143 : q);
                exp_sat.push_back(q > 262143);
            end
            for (int i = 0; i < CoreN; i++) begin
                if (iDone[i]) begin
                    if (!slot_full[i] || take) begin
                        slot_val[i]  = longint'(iAcc[i*AccWidth +: AccWidth]);
                        slot_full[i] = 1;
                    end else begin
                        m_overrun = 1;
                    end
                end else if (take) begin
                    slot_full[i] = 0;
                end
            end
            if (accept) begin
                m_valid   = 0;
                m_engaged = 0;
                m_count   = (m_count + 1) % 65536;
                void'(exp_mean.pop_front());
                void'(exp_sat.pop_front());
            end
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) m_valid = 1;
            end
            if (take) begin
                m_engaged = 1;
                m_cd      = CoreN + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #4;
            checkOutput("cyc_valid", oValid, m_valid);
            checkOutput("cyc_busy", oBusy, m_cd > 0);
            checkOutput("cyc_overrun", oOverrun, m_overrun);
            checkOutput("cyc_count", oCount, m_count);
            if (m_valid && exp_mean.size() > 0) begin
                checkOutput("cyc_mean", oMean, exp_mean[0]);
                checkOutput("cyc_sat", oSat, exp_sat[0]);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] done, input logic [26:0] a0, input logic [26:0] a1);
        @(negedge CLK);
        iDone = done;
        iAcc  = {a1, a0};
        @(negedge CLK);
        iDone = '0;
    endtask

    task automatic waitValid(input int bound);
        bit seen;
        seen = 0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(posedge CLK);
            #1;
            if (oValid) seen = 1;
        end
        checkOutput("valid_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #2;
        checkOutput("rst_valid", oValid, 0);
        checkOutput("rst_mean", oMean, 0);
        checkOutput("rst_count", oCount, 0);
        checkOutput("rst_busy", oBusy, 0);
        repeat (2) @(negedge CLK);
        iRST_n = 1'b1;

        // Simultaneous done, exact latency of four edges.
        applyStimulus(2'b11, 27'd3072, 27'd1024);
        repeat (3) @(posedge CLK);
        #1 checkOutput("basic_early", oValid, 0);
        @(posedge CLK);
        #1;
        checkOutput("basic_valid", oValid, 1);
        checkOutput("basic_mean", oMean, 8);
        checkOutput("basic_sat", oSat, 0);
        @(posedge CLK);
        #1;
        checkOutput("basic_drop", oValid, 0);
        checkOutput("basic_count", oCount, 1);

        // Core1 first, core0 seven cycles later.
        applyStimulus(2'b10, 27'd0, 27'd512);
        repeat (5) @(negedge CLK);
        checkOutput("stag_wait", oValid, 0);
        applyStimulus(2'b01, 27'd512, 27'd0);
        repeat (3) @(posedge CLK);
        #1 checkOutput("stag_early", oValid, 0);
        @(posedge CLK);
        #1 checkOutput("stag_mean", oMean, 2);
        @(posedge CLK);

        // Saturation then recovery.
        applyStimulus(2'b11, 27'h7FFFFFF, 27'h7FFFFFF);
        waitValid(10);
        checkOutput("sat_mean", oMean, 262143);
        checkOutput("sat_flag", oSat, 1);
        @(posedge CLK);
        applyStimulus(2'b11, 27'd1024, 27'd0);
        waitValid(10);
        checkOutput("unsat_mean", oMean, 2);
        checkOutput("unsat_flag", oSat, 0);
        @(posedge CLK);

        // Backpressure with a queued batch and a dropped third pulse.
        @(negedge CLK);
        iReady = 1'b0;
        applyStimulus(2'b11, 27'd5120, 27'd0);
        waitValid(10);
        checkOutput("bp_mean", oMean, 10);
        applyStimulus(2'b11, 27'd1536, 27'd1024);
        applyStimulus(2'b01, 27'd100000, 27'd0);
        @(posedge CLK);
        #1;
        checkOutput("bp_overrun", oOverrun, 1);
        checkOutput("bp_hold_valid", oValid, 1);
        checkOutput("bp_hold_mean", oMean, 10);
        repeat (10) @(negedge CLK);
        checkOutput("bp_hold_late", oMean, 10);
        iReady = 1'b1;
        @(posedge CLK);
        waitValid(10);
        checkOutput("bp_second_mean", oMean, 5);
        @(posedge CLK);
        #1 checkOutput("bp_count", oCount, 6);

        // Reset in the middle of SUM.
        applyStimulus(2'b11, 27'd2048, 27'd2048);
        @(posedge CLK);
        #1 checkOutput("sum_busy", oBusy, 1);
        #2 iRST_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", oValid, 0);
        checkOutput("mid_rst_busy", oBusy, 0);
        checkOutput("mid_rst_overrun", oOverrun, 0);
        checkOutput("mid_rst_count", oCount, 0);
        checkOutput("mid_rst_mean", oMean, 0);
        repeat (2) @(negedge CLK);
        iRST_n = 1'b1;
        applyStimulus(2'b11, 27'd2560, 27'd0);
        waitValid(10);
        checkOutput("post_rst_mean", oMean, 5);
        @(posedge CLK);
        #1 checkOutput("post_rst_count", oCount, 1);

        // Counter wrap, starting two acceptances short of 65536.
        @(negedge CLK);
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        m_count = 65534;
        applyStimulus(2'b11, 27'd512, 27'd512);
        waitValid(10);
        @(posedge CLK);
        #1 checkOutput("wrap_ffff", oCount, 65535);
        applyStimulus(2'b11, 27'd0, 27'd0);
        waitValid(10);
        checkOutput("wrap_zero_mean", oMean, 0);
        @(posedge CLK);
        #1 checkOutput("wrap_zero", oCount, 0);

        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
